// File: rtl/ad9226_pkg.sv
// Shared AD9226 sample-path types and helpers: channel count, channel index,
// packer FSM states and offset-binary to two's-complement conversion.
package ad9226_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  typedef enum logic {IDLE, SEND} state_t;

  // Flip the MSB of a width-bit offset-binary word and sign-extend to 32 bits.
  function automatic logic [31:0] offset_to_twos(input logic [31:0] word,
                                                 input int unsigned width);
    logic [31:0] low_mask;
    logic [31:0] shifted;
    logic        msb;
    low_mask = (32'd1 << (width - 1)) - 32'd1;
    shifted  = word >> (width - 1);
    msb      = ~shifted[0];
    return (word & low_mask) | (msb ? ~low_mask : 32'd0);
  endfunction

  // Channels strictly above ch.
  function automatic logic [NUM_CH-1:0] mask_above(input ch_idx_t ch);
    return NUM_CH'(4'b1110 << ch);
  endfunction

  // Lowest set channel of a mask; only meaningful when the mask is non-zero.
  function automatic ch_idx_t lowest_set(input logic [NUM_CH-1:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/ad9226_axis_packer_if.sv
// AXI4-Stream sample bus carrying one ADC channel per beat.
interface ad9226_axis_packer_if
  import ad9226_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 16
) ();

  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  ch_idx_t                    tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/ad9226_sample_format.sv
// Combinational ADC word to stream word: zero-extend, or offset-binary to
// sign-extended two's complement when SIGNED_OUT is set.
module ad9226_sample_format
  import ad9226_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH  = 12,
  parameter int unsigned AXIS_DATA_WIDTH = 16,
  parameter int unsigned SIGNED_OUT      = 0
) (
  input  logic [ADC_DATA_WIDTH-1:0]  word,
  output logic [AXIS_DATA_WIDTH-1:0] tdata_c
);

  logic [31:0] ext;

  always_comb begin
    ext     = (SIGNED_OUT != 0) ? offset_to_twos(32'(word), ADC_DATA_WIDTH) : 32'(word);
    tdata_c = AXIS_DATA_WIDTH'(ext);
  end

endmodule

// File: rtl/ad9226_axis_packer.sv
// Captures the four AD9226 channel words on each end-of-conversion edge and
// streams the enabled channels as AXI4-Stream beats, grouped into packets.
module ad9226_axis_packer
  import ad9226_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH  = 12,
  parameter int unsigned AXIS_DATA_WIDTH = 16,
  parameter int unsigned PACKET_SETS     = 256,
  parameter int unsigned SIGNED_OUT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic                      eoc,
  input  logic [ADC_DATA_WIDTH-1:0] data_in0,
  input  logic [ADC_DATA_WIDTH-1:0] data_in1,
  input  logic [ADC_DATA_WIDTH-1:0] data_in2,
  input  logic [ADC_DATA_WIDTH-1:0] data_in3,
  ad9226_axis_packer_if.master      m_axis,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int unsigned CNT_W = (PACKET_SETS > 1) ? $clog2(PACKET_SETS) : 1;
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(PACKET_SETS - 1);

  state_t                     state_q, state_d;
  logic                       eoc_q;
  logic [ADC_DATA_WIDTH-1:0]  din    [NUM_CH];
  logic [ADC_DATA_WIDTH-1:0]  hold_q [NUM_CH];
  logic [NUM_CH-1:0]          mask_q, mask_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  ch_idx_t                    tuser_q, tuser_d;
  logic                       overflow_q, overflow_d;

  logic                       start, hs, last_beat, accept, from_input, load;
  logic [NUM_CH-1:0]          rem, beat_mask;
  ch_idx_t                    beat_ch;
  logic [ADC_DATA_WIDTH-1:0]  src_word;
  logic [AXIS_DATA_WIDTH-1:0] fmt_word;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
    return (c == LAST_SET) ? '0 : c + CNT_W'(1);
  endfunction

  always_comb begin
    din[0] = data_in0;
    din[1] = data_in1;
    din[2] = data_in2;
    din[3] = data_in3;
  end

  // Next-beat selection: a freshly accepted set reads the live inputs, an
  // in-flight set reads the holding registers.
  always_comb begin
    start      = eoc & ~eoc_q & enable;
    hs         = tvalid_q & m_axis.tready;
    rem        = mask_q & mask_above(tuser_q);
    last_beat  = (rem == '0);
    accept     = start & ((state_q == IDLE) | (hs & last_beat));
    from_input = accept & (ch_enable != '0);
    beat_mask  = from_input ? ch_enable : mask_q;
    beat_ch    = from_input ? lowest_set(ch_enable) : lowest_set(rem);
    src_word   = from_input ? din[beat_ch] : hold_q[beat_ch];
  end

  ad9226_sample_format #(
    .ADC_DATA_WIDTH  (ADC_DATA_WIDTH),
    .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
    .SIGNED_OUT      (SIGNED_OUT)
  ) u_format (
    .word    (src_word),
    .tdata_c (fmt_word)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    tuser_d    = tuser_q;
    overflow_d = overflow_q & ~clear_overflow;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (start) begin
          if (ch_enable == '0) cnt_d = next_cnt(cnt_q);
          else                 load  = 1'b1;
        end
      end
      SEND: begin
        if (hs && last_beat) begin
          cnt_d = next_cnt(cnt_q);
          if (start && ch_enable != '0) begin
            load = 1'b1;
          end else begin
            // An empty-mask set arriving on the final handshake still counts.
            if (start) cnt_d = next_cnt(cnt_d);
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else begin
          if (hs)    load       = 1'b1;
          if (start) overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) mask_d = ch_enable;

    if (load) begin
      state_d  = SEND;
      tvalid_d = 1'b1;
      tuser_d  = beat_ch;
      tdata_d  = fmt_word;
      tlast_d  = ((beat_mask & mask_above(beat_ch)) == '0) && (cnt_d == LAST_SET);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      eoc_q      <= 1'b0;
      mask_q     <= '0;
      cnt_q      <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      eoc_q      <= eoc;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tuser_q    <= tuser_d;
      overflow_q <= overflow_d;
      if (accept) hold_q <= din;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ad9226_axis_packer.sv
// Directed bench for ad9226_axis_packer: one unsigned and one signed instance
// (PACKET_SETS=4) driven from shared inputs.
module tb_ad9226_axis_packer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  ch_enable;
  logic        eoc;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic        tready;
  logic        clear_overflow;
  logic        ovf0, ovf1;

  int vectors;
  int errors;

  ad9226_axis_packer_if #(.AXIS_DATA_WIDTH(16)) ax0 ();
  ad9226_axis_packer_if #(.AXIS_DATA_WIDTH(16)) ax1 ();

  assign ax0.tready = tready;
  assign ax1.tready = tready;

  ad9226_axis_packer #(
    .ADC_DATA_WIDTH(12), .AXIS_DATA_WIDTH(16), .PACKET_SETS(4), .SIGNED_OUT(0)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable), .eoc(eoc),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .m_axis(ax0), .overflow(ovf0), .clear_overflow(clear_overflow)
  );

  ad9226_axis_packer #(
    .ADC_DATA_WIDTH(12), .AXIS_DATA_WIDTH(16), .PACKET_SETS(4), .SIGNED_OUT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable), .eoc(eoc),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .m_axis(ax1), .overflow(ovf1), .clear_overflow(clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [1:0] u,
                             input logic [15:0] d, input logic l);
    chk({tag, ".tvalid"}, 32'(ax0.tvalid), 32'd1);
    chk({tag, ".tuser"},  32'(ax0.tuser),  32'(u));
    chk({tag, ".tdata"},  32'(ax0.tdata),  32'(d));
    chk({tag, ".tlast"},  32'(ax0.tlast),  32'(l));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".tvalid"}, 32'(ax0.tvalid), 32'd0);
  endtask

  // One single-channel set on channel 0, then one idle cycle.
  task automatic simple_set(input string tag, input logic [11:0] d, input logic l);
    data_in0  = d;
    ch_enable = 4'b0001;
    eoc       = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_beat(tag, 2'd0, 16'(d), l);
    cyc();
    expect_idle({tag, ".after"});
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1; enable = 1'b1; ch_enable = 4'b0000; eoc = 1'b0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    tready = 1'b1; clear_overflow = 1'b0;
    cyc(); cyc();
    chk("rst.tvalid",   32'(ax0.tvalid), 32'd0);
    chk("rst.tlast",    32'(ax0.tlast),  32'd0);
    chk("rst.tdata",    32'(ax0.tdata),  32'd0);
    chk("rst.tuser",    32'(ax0.tuser),  32'd0);
    chk("rst.overflow", 32'(ovf0),       32'd0);
    rst = 1'b0;
    cyc();

    // Basic four-channel set, set counter 0 -> 1
    data_in0 = 12'h123; data_in1 = 12'h456; data_in2 = 12'h789; data_in3 = 12'hABC;
    ch_enable = 4'b1111; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_beat("basic0", 2'd0, 16'h0123, 1'b0); cyc();
    expect_beat("basic1", 2'd1, 16'h0456, 1'b0); cyc();
    expect_beat("basic2", 2'd2, 16'h0789, 1'b0); cyc();
    expect_beat("basic3", 2'd3, 16'h0ABC, 1'b0); cyc();
    expect_idle("basic.end");

    // Mask 1010 with signed formatting on dut1, unsigned on dut0
    data_in1 = 12'h000; data_in3 = 12'hFFF; ch_enable = 4'b1010; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    chk("fmt0.tuser", 32'(ax1.tuser), 32'd1);
    chk("fmt0.tdata", 32'(ax1.tdata), 32'hF800);
    chk("fmt0.u.tdata", 32'(ax0.tdata), 32'h0000);
    cyc();
    chk("fmt1.tuser", 32'(ax1.tuser), 32'd3);
    chk("fmt1.tdata", 32'(ax1.tdata), 32'h07FF);
    chk("fmt1.u.tdata", 32'(ax0.tdata), 32'h0FFF);
    cyc();
    chk("fmt.end", 32'(ax1.tvalid), 32'd0);

    // Packet boundary from a fresh counter
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int n = 0; n < 9; n++)
      simple_set($sformatf("pkt%0d", n), 12'(n + 1), (n == 3) || (n == 7));

    // Back-pressure with a dropped set (counter at 1)
    data_in0 = 12'h111; data_in1 = 12'h222; data_in2 = 12'h333; data_in3 = 12'h444;
    ch_enable = 4'b1111; tready = 1'b0; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_beat("bp0", 2'd0, 16'h0111, 1'b0);
    cyc();
    data_in0 = 12'h999; data_in1 = 12'h998; data_in2 = 12'h997; data_in3 = 12'h996;
    eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    chk("bp.overflow", 32'(ovf0), 32'd1);
    chk("bp.hold", 32'(ax0.tdata), 32'h0111);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("bp.stall%0d", i), 32'(ax0.tdata), 32'h0111);
    end
    tready = 1'b1;
    cyc();
    expect_beat("bp1", 2'd1, 16'h0222, 1'b0); cyc();
    expect_beat("bp2", 2'd2, 16'h0333, 1'b0); cyc();
    expect_beat("bp3", 2'd3, 16'h0444, 1'b0); cyc();
    expect_idle("bp.end"); cyc();
    expect_idle("bp.nodrop");
    chk("bp.sticky", 32'(ovf0), 32'd1);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    chk("bp.clear", 32'(ovf0), 32'd0);

    // Back-to-back acceptance on the final handshake (counter 2 -> 3 -> 0)
    data_in0 = 12'h0A1; data_in1 = 12'h0B2; ch_enable = 4'b0011; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_beat("b2b0", 2'd0, 16'h00A1, 1'b0); cyc();
    expect_beat("b2b1", 2'd1, 16'h00B2, 1'b0);
    data_in0 = 12'h0C3; data_in1 = 12'h0D4; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_beat("b2b2", 2'd0, 16'h00C3, 1'b0);
    chk("b2b.overflow", 32'(ovf0), 32'd0);
    cyc();
    expect_beat("b2b3", 2'd1, 16'h00D4, 1'b1);
    cyc();
    expect_idle("b2b.end");

    // Reset mid-set restarts the packet count
    simple_set("pre0", 12'h010, 1'b0);
    simple_set("pre1", 12'h011, 1'b0);
    ch_enable = 4'b1111; tready = 1'b0; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    chk("mid.tvalid", 32'(ax0.tvalid), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mrst.tvalid", 32'(ax0.tvalid), 32'd0);
    chk("mrst.tdata",  32'(ax0.tdata),  32'd0);
    chk("mrst.tuser",  32'(ax0.tuser),  32'd0);
    rst = 1'b0; tready = 1'b1;
    cyc();
    for (int n = 0; n < 4; n++)
      simple_set($sformatf("post%0d", n), 12'(12'h020 + n), n == 3);

    // enable=0: no capture and the counter is cleared
    simple_set("en0", 12'h030, 1'b0);
    simple_set("en1", 12'h031, 1'b0);
    enable = 1'b0; ch_enable = 4'b1111; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_idle("dis0"); cyc();
    expect_idle("dis1");
    enable = 1'b1;
    cyc();
    // Empty-mask set counts without beats
    ch_enable = 4'b0000; eoc = 1'b1;
    cyc();
    eoc = 1'b0;
    expect_idle("empty0"); cyc();
    expect_idle("empty1");
    simple_set("tail0", 12'h040, 1'b0);
    simple_set("tail1", 12'h041, 1'b0);
    simple_set("tail2", 12'h042, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
